// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// programmable bubble value. Define PIPE_STAGE_REG_SKID_EN for a second (skid) entry.
module pipe_stage_reg #(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding equals the entry count, so the state register drives occupancy directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic             valid_q;
  logic             valid_nxt;
  logic             accept;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             ready_q;
  logic             ready_nxt;

  assign in_ready = ready_q;
`else
  assign in_ready = ~valid_q | out_ready;
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign occupancy = state;

  // State register and datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      main_q  <= RESET_VALUE;
      valid_q <= 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q  <= RESET_VALUE;
      ready_q <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      valid_q <= valid_nxt;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q  <= skid_nxt;
      ready_q <= ready_nxt;
`endif
    end
  end

  // Next-state logic; flush overrides every transfer.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = FULL;
        FULL: begin
          if (out_ready) begin
            if (!accept) state_nxt = EMPTY;
          end
`ifdef PIPE_STAGE_REG_SKID_EN
          else if (accept) begin
            state_nxt = SKID;
          end
        end
        SKID: begin
          if (out_ready) state_nxt = FULL;
`endif
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Next values of the registered outputs and the data entries.
  always_comb begin
    main_nxt  = main_q;
    valid_nxt = (state_nxt != EMPTY);
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_nxt  = skid_q;
    ready_nxt = (state_nxt != SKID);
`endif
    if (flush) begin
      main_nxt = RESET_VALUE;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_nxt = RESET_VALUE;
`endif
    end else begin
      if (accept && (state == EMPTY || out_ready)) begin
        main_nxt = in_data;
      end
`ifdef PIPE_STAGE_REG_SKID_EN
      if (accept && state == FULL && !out_ready) begin
        skid_nxt = in_data;
      end
      if (state == SKID && out_ready) begin
        main_nxt = skid_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: two instances (bubble 0000 and FFFF)
// driven in lockstep and checked against a FIFO-queue reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        out_ready = 1'b0;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [15:0] out_data0, out_data1;
  logic [1:0]  occupancy0, occupancy1;

  int          n_vec = 0;
  int          n_err = 0;

  // Reference model: ordered contents plus the last word that left the stage.
  logic [15:0] exp_q[$];
  logic [15:0] last0, last1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  pipe_stage_reg #(.WIDTH(16), .RESET_VALUE(16'hFFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic ordy);
`ifdef PIPE_STAGE_REG_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || ordy;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last0 = 16'h0000;
    last1 = 16'hFFFF;
  endtask

  task automatic check_outs();
    logic        v;
    logic [15:0] h0, h1;
    v  = exp_q.size() > 0;
    h0 = v ? exp_q[0] : last0;
    h1 = v ? exp_q[0] : last1;
    chk("out_valid0", {15'b0, out_valid0}, {15'b0, v});
    chk("out_valid1", {15'b0, out_valid1}, {15'b0, v});
    chk("out_data0", out_data0, h0);
    chk("out_data1", out_data1, h1);
    chk("occupancy0", {14'b0, occupancy0}, 16'(exp_q.size()));
    chk("occupancy1", {14'b0, occupancy1}, 16'(exp_q.size()));
  endtask

  // One clock cycle: check state, drive inputs, check in_ready, advance model at the edge.
  task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    logic rdy;
    @(negedge clk);
    check_outs();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = model_ready(ordy);
    chk("in_ready0", {15'b0, in_ready0}, {15'b0, rdy});
    chk("in_ready1", {15'b0, in_ready1}, {15'b0, rdy});
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0 && ordy) begin
        last0 = exp_q.pop_front();
        last1 = last0;
      end
      if (iv && rdy) exp_q.push_back(d);
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("rst_in_ready0", {15'b0, in_ready0}, 16'h0001);
    chk("rst_in_ready1", {15'b0, in_ready1}, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    do_reset();

    // Streaming at full throughput.
    step(1'b1, 16'h1111, 1'b1, 1'b0);
    step(1'b1, 16'h2222, 1'b1, 1'b0);
    step(1'b1, 16'h3333, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Stall with back-pressure, then release.
    step(1'b1, 16'hA0A0, 1'b0, 1'b0);
    step(1'b1, 16'hB0B0, 1'b0, 1'b0);
    step(1'b1, 16'hC0C0, 1'b0, 1'b0);
    step(1'b1, 16'hC0C0, 1'b1, 1'b0);
    step(1'b1, 16'hC0C0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush while held, with a concurrent word offered.
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    step(1'b1, 16'h6666, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b1);
    repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Drain to empty: last value persists rather than the bubble value.
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush plus reset together.
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           16'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
      if ($urandom_range(0, 150) == 0) do_reset();
    end

    @(negedge clk);
    check_outs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
